// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: 640x480@60 defaults, timing-set struct and total helper.
package vga_pkg;

  localparam int unsigned DefClkDiv  = 2;
  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFront  = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBack   = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFront  = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBack   = 33;

  typedef struct packed {
    int unsigned active;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } timing_t;

  function automatic int unsigned timing_total(timing_t t);
    return t.active + t.front + t.sync + t.back;
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-enable strobe generator: one strobe every CLK_DIV system clocks while en is high.
module vga_pix_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic pix_en
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  // primed_q delays counting by one clk so pixel (0,0) is shown for a full CLK_DIV period
  logic            primed_q;

  always_comb begin
    div_d = div_q;
    if (en && primed_q) begin
      div_d = (div_q == DivLast) ? '0 : div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      div_q <= div_d;
      if (en) begin
        primed_q <= 1'b1;
      end
    end
  end

  assign pix_en = en && primed_q && (div_q == DivLast);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel strobe, x/y counters, registered sync/video decode.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DefClkDiv,
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FRONT  = DefHFront,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BACK   = DefHBack,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FRONT  = DefVFront,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BACK   = DefVBack,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned FRM_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             pix_en,
  output logic             h_sync,
  output logic             v_sync,
  output logic             video_on,
  output logic [CNT_W-1:0] x_loc,
  output logic [CNT_W-1:0] y_loc,
  output logic             line_start,
  output logic             frame_start,
  output logic [FRM_W-1:0] frame_cnt
);

  localparam timing_t HTiming = '{active: H_ACTIVE, front: H_FRONT, sync: H_SYNC, back: H_BACK};
  localparam timing_t VTiming = '{active: V_ACTIVE, front: V_FRONT, sync: V_SYNC, back: V_BACK};
  localparam int unsigned HTotal = timing_total(HTiming);
  localparam int unsigned VTotal = timing_total(VTiming);
  localparam longint unsigned CntRange = 64'd1 << CNT_W;

  if (CLK_DIV < 1 || longint'(HTotal) > CntRange || longint'(VTotal) > CntRange) begin : g_bad_cfg
    $error("vga_timing_gen: CLK_DIV must be >= 1 and H/V totals must fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] HLast     = CNT_W'(HTotal - 1);
  localparam logic [CNT_W-1:0] VLast     = CNT_W'(VTotal - 1);
  localparam logic [CNT_W-1:0] HAct      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VAct      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HSyncBeg  = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HSyncEnd  = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VSyncBeg  = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VSyncEnd  = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic             video_q, video_d;
  logic             hs_q, hs_d, vs_q, vs_d;

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .pix_en (pix_en)
  );

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    frm_d = frm_q;
    if (pix_en) begin
      if (x_q == HLast) begin
        x_d = '0;
        if (y_q == VLast) begin
          y_d   = '0;
          frm_d = frm_q + 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Decode the next position so the registered levels line up with x_loc/y_loc
  always_comb begin
    video_d = (x_d < HAct) && (y_d < VAct);
    hs_d    = ((x_d >= HSyncBeg) && (x_d < HSyncEnd)) ? H_POL : ~H_POL;
    vs_d    = ((y_d >= VSyncBeg) && (y_d < VSyncEnd)) ? V_POL : ~V_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      frm_q   <= '0;
      video_q <= 1'b0;
      hs_q    <= ~H_POL;
      vs_q    <= ~V_POL;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      frm_q <= frm_d;
      if (en) begin
        video_q <= video_d;
        hs_q    <= hs_d;
        vs_q    <= vs_d;
      end
    end
  end

  assign x_loc       = x_q;
  assign y_loc       = y_q;
  assign frame_cnt   = frm_q;
  assign video_on    = video_q;
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign line_start  = pix_en && (x_q == '0);
  assign frame_start = line_start && (y_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a CLK_DIV=2 instance with 800-pixel lines and short frames, plus a tiny CLK_DIV=1 instance.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en_a = 1'b0;
  logic en_b = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   fs_cyc = 0;

  logic       a_pix, a_hs, a_vs, a_video, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic [1:0] a_frm;
  logic       b_pix, b_hs, b_vs, b_video, b_ls, b_fs;
  logic [3:0] b_x, b_y;
  logic [7:0] b_frm;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_POL(1'b0), .V_POL(1'b0), .CNT_W(10), .FRM_W(2)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .pix_en(a_pix), .h_sync(a_hs), .v_sync(a_vs),
    .video_on(a_video), .x_loc(a_x), .y_loc(a_y), .line_start(a_ls), .frame_start(a_fs),
    .frame_cnt(a_frm)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1'b1), .V_POL(1'b1), .CNT_W(4), .FRM_W(8)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .pix_en(b_pix), .h_sync(b_hs), .v_sync(b_vs),
    .video_on(b_video), .x_loc(b_x), .y_loc(b_y), .line_start(b_ls), .frame_start(b_fs),
    .frame_cnt(b_frm)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    tick(2);
    n_vec++; if (a_x !== 10'd0) begin n_err++; $display("FAIL reset_a_x got %0d want 0", a_x); end
    n_vec++; if (a_y !== 10'd0) begin n_err++; $display("FAIL reset_a_y got %0d want 0", a_y); end
    n_vec++; if (a_frm !== 2'd0) begin n_err++; $display("FAIL reset_a_frm got %0d want 0", a_frm); end
    n_vec++;
    if ({a_pix, a_ls, a_fs, a_video, a_hs, a_vs} !== 6'b000011) begin
      n_err++; $display("FAIL reset_a_bits got %b want 000011", {a_pix, a_ls, a_fs, a_video, a_hs, a_vs});
    end
    n_vec++;
    if ({b_pix, b_ls, b_fs, b_video, b_hs, b_vs} !== 6'b000000) begin
      n_err++; $display("FAIL reset_b_bits got %b want 000000", {b_pix, b_ls, b_fs, b_video, b_hs, b_vs});
    end
    n_vec++; if (b_x !== 4'd0) begin n_err++; $display("FAIL reset_b_x got %0d want 0", b_x); end
    // Release with en low: nothing may start
    rst_n = 1'b1;
    tick(3);
    n_vec++;
    if ({a_pix, a_video, b_pix, b_video} !== 4'b0000) begin
      n_err++; $display("FAIL idle_en_low got %b want 0000", {a_pix, a_video, b_pix, b_video});
    end
  endtask

  task automatic test_small_timing;
    en_b = 1'b1;
    tick(1);
    for (int p = 0; p < 196; p++) begin
      int ex, ey;
      logic [5:0] eb;
      ex = p % 14;
      ey = (p / 14) % 7;
      eb = {1'b1, (ex == 10 || ex == 11), (ey == 5), (ex < 8 && ey < 4), (ex == 0),
            (ex == 0 && ey == 0)};
      n_vec++; if (b_x !== 4'(ex)) begin n_err++; $display("FAIL small_x p=%0d got %0d want %0d", p, b_x, ex); end
      n_vec++; if (b_y !== 4'(ey)) begin n_err++; $display("FAIL small_y p=%0d got %0d want %0d", p, b_y, ey); end
      n_vec++;
      if ({b_pix, b_hs, b_vs, b_video, b_ls, b_fs} !== eb) begin
        n_err++;
        $display("FAIL small_bits p=%0d got %b want %b", p, {b_pix, b_hs, b_vs, b_video, b_ls, b_fs}, eb);
      end
      n_vec++;
      if (b_frm !== 8'(p / 98)) begin
        n_err++; $display("FAIL small_frm p=%0d got %0d want %0d", p, b_frm, p / 98);
      end
      tick(1);
    end
    en_b = 1'b0;
  endtask

  task automatic test_pix_div;
    en_a = 1'b1;
    tick(1);
    for (int k = 1; k <= 200; k++) begin
      logic ep;
      int   ex;
      ep = ((k - 1) % 2) == 1;
      ex = (k - 1) / 2;
      if (a_fs && k == 2) fs_cyc = cyc;
      n_vec++; if (a_pix !== ep) begin n_err++; $display("FAIL div_pix k=%0d got %0d want %0d", k, a_pix, ep); end
      n_vec++; if (a_x !== 10'(ex)) begin n_err++; $display("FAIL div_x k=%0d got %0d want %0d", k, a_x, ex); end
      n_vec++;
      if ({a_video, a_ls, a_fs, a_y} !== {1'b1, ep && ex == 0, ep && ex == 0, 10'd0}) begin
        n_err++; $display("FAIL div_misc k=%0d got %b want video=1 ls=fs=%0d y=0", k,
                          {a_video, a_ls, a_fs, a_y}, ep && ex == 0);
      end
      tick(1);
    end
    n_vec++;
    if (a_x !== 10'd100 || a_pix !== 1'b0) begin
      n_err++; $display("FAIL div_at100 got x=%0d pix=%0d want x=100 pix=0", a_x, a_pix);
    end
  endtask

  task automatic test_en_stall;
    en_a = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (a_x !== 10'd100 || a_pix !== 1'b0 || a_ls !== 1'b0) begin
        n_err++; $display("FAIL stall_hold i=%0d got x=%0d pix=%0d want x=100 pix=0", i, a_x, a_pix);
      end
      tick(1);
    end
    en_a = 1'b1;
    #1;
    n_vec++; if (a_pix !== 1'b0) begin n_err++; $display("FAIL stall_resume0 got pix=%0d want 0", a_pix); end
    tick(1);
    n_vec++;
    if (a_pix !== 1'b1 || a_x !== 10'd100) begin
      n_err++; $display("FAIL stall_resume1 got x=%0d pix=%0d want x=100 pix=1", a_x, a_pix);
    end
    tick(1);
    n_vec++;
    if (a_pix !== 1'b0 || a_x !== 10'd101 || a_y !== 10'd0) begin
      n_err++; $display("FAIL stall_resume2 got x=%0d y=%0d pix=%0d want 101 0 0", a_x, a_y, a_pix);
    end
  endtask

  task automatic test_hsync_line;
    int cnt = 0, xmin = 1023, xmax = 0, bad = 0, start, guard;
    bit found = 0;
    for (guard = 0; guard < 2000 && !found; guard++) begin
      tick(1);
      if (!a_hs) begin
        if (a_x < 10'd656 || a_x > 10'd751) bad++;
        if (a_pix) begin
          cnt++;
          if (int'(a_x) < xmin) xmin = int'(a_x);
          if (int'(a_x) > xmax) xmax = int'(a_x);
        end
      end
      if (a_ls) found = 1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL hs_timeout got none want line_start"); end
    n_vec++; if (cnt != 96) begin n_err++; $display("FAIL hs_width got %0d want 96", cnt); end
    n_vec++; if (xmin != 656) begin n_err++; $display("FAIL hs_first got %0d want 656", xmin); end
    n_vec++; if (xmax != 751) begin n_err++; $display("FAIL hs_last got %0d want 751", xmax); end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL hs_outside got %0d want 0", bad); end
    n_vec++; if (a_y !== 10'd1) begin n_err++; $display("FAIL hs_next_y got %0d want 1", a_y); end
    start = cyc;
    found = 0;
    for (guard = 0; guard < 2000 && !found; guard++) begin
      tick(1);
      if (a_ls) found = 1;
    end
    n_vec++;
    if (!found || cyc - start != 1600 || a_y !== 10'd2) begin
      n_err++; $display("FAIL line_period got %0d clks y=%0d want 1600 y=2", cyc - start, a_y);
    end
  endtask

  task automatic test_frame;
    int start, vid = 0, vs_lines = 0, ymin = 1023, ymax = 0, guard;
    bit found = 0;
    for (guard = 0; guard < 15000 && !found; guard++) begin
      tick(1);
      if (a_fs) found = 1;
    end
    n_vec++;
    if (!found || cyc - fs_cyc != 12805) begin
      n_err++; $display("FAIL frame0_period got %0d want 12805", cyc - fs_cyc);
    end
    n_vec++; if (a_frm !== 2'd1) begin n_err++; $display("FAIL frame_cnt1 got %0d want 1", a_frm); end
    start = cyc;
    found = 0;
    for (guard = 0; guard < 15000 && !found; guard++) begin
      tick(1);
      if (a_pix && a_video) vid++;
      if (a_ls && !a_vs) begin
        vs_lines++;
        if (int'(a_y) < ymin) ymin = int'(a_y);
        if (int'(a_y) > ymax) ymax = int'(a_y);
      end
      if (a_fs) found = 1;
    end
    n_vec++;
    if (!found || cyc - start != 12800) begin
      n_err++; $display("FAIL frame_period got %0d want 12800", cyc - start);
    end
    n_vec++; if (vid != 2560) begin n_err++; $display("FAIL video_pixels got %0d want 2560", vid); end
    n_vec++;
    if (vs_lines != 2 || ymin != 5 || ymax != 6) begin
      n_err++; $display("FAIL vs_lines got n=%0d y=%0d..%0d want n=2 y=5..6", vs_lines, ymin, ymax);
    end
    n_vec++; if (a_frm !== 2'd2) begin n_err++; $display("FAIL frame_cnt2 got %0d want 2", a_frm); end
  endtask

  task automatic test_frame_wrap;
    logic [1:0] want [2];
    want[0] = 2'd3;
    want[1] = 2'd0;
    for (int f = 0; f < 2; f++) begin
      bit found = 0;
      for (int guard = 0; guard < 15000 && !found; guard++) begin
        tick(1);
        if (a_fs) found = 1;
      end
      n_vec++;
      if (!found || a_frm !== want[f]) begin
        n_err++; $display("FAIL frame_wrap f=%0d got %0d want %0d", f, a_frm, want[f]);
      end
      n_vec++;
      if ({a_hs, a_vs, a_video} !== 3'b111) begin
        n_err++; $display("FAIL wrap_sync f=%0d got %b want 111", f, {a_hs, a_vs, a_video});
      end
    end
  endtask

  task automatic test_async_reset;
    bit found = 0;
    for (int guard = 0; guard < 15000 && !found; guard++) begin
      tick(1);
      if (a_x == 10'd700 && a_y == 10'd5) found = 1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL arst_reach got x=%0d y=%0d want 700 5", a_x, a_y); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (a_x !== 10'd0 || a_y !== 10'd0 || a_frm !== 2'd0) begin
      n_err++; $display("FAIL arst_cnt got x=%0d y=%0d frm=%0d want 0 0 0", a_x, a_y, a_frm);
    end
    n_vec++;
    if ({a_pix, a_ls, a_fs, a_video, a_hs, a_vs} !== 6'b000011) begin
      n_err++; $display("FAIL arst_bits got %b want 000011", {a_pix, a_ls, a_fs, a_video, a_hs, a_vs});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    n_vec++;
    if (a_video !== 1'b1 || a_pix !== 1'b0 || a_x !== 10'd0 || a_y !== 10'd0) begin
      n_err++; $display("FAIL arst_first got video=%0d pix=%0d x=%0d want 1 0 0", a_video, a_pix, a_x);
    end
    tick(1);
    n_vec++;
    if (a_pix !== 1'b1 || a_fs !== 1'b1 || a_x !== 10'd0) begin
      n_err++; $display("FAIL arst_fs got pix=%0d fs=%0d x=%0d want 1 1 0", a_pix, a_fs, a_x);
    end
    tick(1);
    n_vec++;
    if (a_pix !== 1'b0 || a_x !== 10'd1) begin
      n_err++; $display("FAIL arst_adv got pix=%0d x=%0d want 0 1", a_pix, a_x);
    end
  endtask

  initial begin
    test_reset();
    test_small_timing();
    test_pix_div();
    test_en_stall();
    test_hsync_line();
    test_frame();
    test_frame_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Replaces the fixed pixel-clock divider, the separate horizontal and vertical counters, and the sync decoder with one synchronous block on the system clock.
- Produces a pixel-enable strobe instead of a derived clock.
- Supports configurable porch, sync and active widths, sync polarity, and clock division.
- Adds line/frame start pulses, a frame counter and a run enable. Feeds the pixel generator and the VGA pins.

Parameters:
- CLK_DIV, 2, system clocks per pixel (>=1; 2 gives 25 MHz from 50 MHz)
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_POL, 0, h_sync active level (0 = active-low)
- V_POL, 0, v_sync active level
- CNT_W, 10, width of x_loc/y_loc
- FRM_W, 8, width of frame_cnt

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; low freezes all timing
- pix_en  out  1  one-clk strobe per pixel period
- h_sync  out  1  horizontal sync, level per H_POL
- v_sync  out  1  vertical sync, level per V_POL
- video_on  out  1  high inside the active area
- x_loc  out  CNT_W  current horizontal count, 0..H_TOTAL-1
- y_loc  out  CNT_W  current vertical count, 0..V_TOTAL-1
- line_start  out  1  pulse on pixel x=0
- frame_start  out  1  pulse on pixel (0,0)
- frame_cnt  out  FRM_W  completed-frame counter, wraps

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800)
  - V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525)
- Elaboration error if H_TOTAL or V_TOTAL > 2**CNT_W, or CLK_DIV < 1.
- Divider: div_cnt counts 0..CLK_DIV-1 while en=1.
  - pix_en=1 in the clk where div_cnt==CLK_DIV-1.
  - CLK_DIV=1: pix_en is high every clk while en=1.
- Counters advance only on the edge where pix_en=1.
  - x wraps H_TOTAL-1 -> 0. When x wraps, y increments.
  - y wraps V_TOTAL-1 -> 0. On that wrap frame_cnt increments, modulo 2**FRM_W.
- Timing: pixel (x,y) is presented for CLK_DIV clks. pix_en marks the last of them.
- Decode, registered and aligned with x_loc/y_loc in the same cycle:
  - video_on = x<H_ACTIVE && y<V_ACTIVE.
  - h_sync active when H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC (656..751).
  - v_sync active when V_ACTIVE+V_FRONT <= y < V_ACTIVE+V_FRONT+V_SYNC (490..491).
  - Sync outputs drive H_POL/V_POL when active, the complement otherwise.
- line_start = pix_en && x==0.
- frame_start = pix_en && x==0 && y==0.
- en=0:
  - div_cnt, counters, frame_cnt and all levels hold.
  - pix_en, line_start and frame_start are 0.
  - en returning to 1 resumes from the held div_cnt with no skipped or duplicated pixel.
- Reset, asynchronous on rst_n=0, any time including mid-line:
  - div_cnt=0, x_loc=0, y_loc=0, frame_cnt=0.
  - pix_en=0, line_start=0, frame_start=0, video_on=0.
  - h_sync=~H_POL, v_sync=~V_POL.
- First clk after reset release with en=1: outputs take the decode of (0,0), so video_on=1.
- First pix_en (with frame_start) occurs CLK_DIV-1 clks after that first clk.

Decomposition:
- Package vga_pkg holds:
  - localparams for the 640x480@60 default timing
  - a timing-set struct typedef (active/front/sync/back) for h and v
  - the derived-total helper function
- One sub-module: vga_pix_div, the en-gated CLK_DIV strobe generator with reset.
- Counters and decode stay in vga_timing_gen.

Test Plan:
- Default params, en=1 after reset:
  - pix_en every 2nd clk.
  - h_sync low for exactly 96 pix_en, from x=656 to x=751.
  - Line period is 1600 clks.
- Full frame run:
  - v_sync low for 2 lines (y=490,491).
  - frame_start every 800*525*2 = 840000 clks.
  - frame_cnt 0->1 at the first y wrap.
  - video_on high for exactly 307200 pixels per frame.
- CLK_DIV=1, H_POL=1, V_POL=1, small timing (8/2/2/2, 4/1/1/1):
  - pix_en constant high.
  - h_sync high only at x=10,11.
  - H_TOTAL=14, V_TOTAL=7.
- en toggled low for 5 clks at x=100, div_cnt=0:
  - x_loc holds at 100 and pix_en stays low.
  - After release, the next pix_en advances x to 101.
  - Frame period stretches by exactly 5 clks.
- rst_n pulsed low at x=700, y=300, with no clk edge:
  - Outputs go immediately to the reset values (h_sync=1, v_sync=1, video_on=0, x=y=0).
  - After release, the sequence restarts from (0,0).
- FRM_W=2, run 4 frames: frame_cnt goes 1,2,3,0 and wraps without glitching sync.
